cpu_controller_fsm: RTL
=======================

Name: cpu_controller_fsm

Overview:
- Next-generation control FSM for the Simple RISC Machine datapath.
- Extends the lab6 start/waiting controller with autonomous instruction fetch, PC update, LDR/STR memory access, HALT and undefined-opcode handling.
- Memory read latency is parametrised and handled by an internal wait counter.
- Sits between the instruction register, the memory interface and the datapath (register file, A/B/C/status registers).

Parameters:
MEM_WAIT, 1, extra cycles a memory read must be held before rdata is valid (0..15)
HALT_ON_UNDEF, 1, 1: undefined opcode enters HALT; 0: treated as NOP (refetch)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
opcode  in  3  IR[15:13]
op  in  2  IR[12:11]
reg_sel  out  2  register-file select: 10=Rn, 00=Rm, 01=Rd
wb_sel  out  2  writeback source: 00=C, 10=sximm8, 11=mdata
w_en  out  1  register-file write enable
en_A  out  1  load A register
en_B  out  1  load B register
en_C  out  1  load C register
en_status  out  1  load Z/N/V
sel_A  out  1  1: A-input forced to 0
sel_B  out  1  1: B-input = sximm5
load_ir  out  1  load instruction register from rdata
load_pc  out  1  load PC
reset_pc  out  1  PC next-value = 0
addr_sel  out  1  1: mem address = PC; 0: data_address register
load_addr  out  1  load data_address register from C
mem_cmd  out  2  00=NONE, 01=READ, 10=WRITE
halted  out  1  FSM is in HALT

Behaviour:
- All outputs are decoded from state only (Moore). Any output not listed for a state is 0 (mem_cmd = NONE).
- rst asserted (async) -> state RESET. RESET drives reset_pc=1 and load_pc=1; all other outputs are 0.
- On the first edge after rst deasserts: RESET -> IF1.
- IF1: addr_sel=1, mem_cmd=READ. Held for 1+MEM_WAIT cycles via a 4-bit counter cleared on entry, then -> IF2.
- IF2: addr_sel=1, mem_cmd=READ, load_ir=1 -> UPDATE_PC.
- UPDATE_PC: load_pc=1 -> DECODE.
- DECODE: all outputs 0. Dispatches on {opcode, op}:
  - 110/10 MOV imm -> WR_IMM
  - 110/00 MOV reg -> READ_B
  - 101/xx ALU -> READ_A
  - 011/00 LDR -> READ_A
  - 100/00 STR -> READ_A
  - 111/xx -> HALT
  - anything else -> HALT if HALT_ON_UNDEF, else IF1
- WR_IMM: reg_sel=10, wb_sel=10, w_en=1 -> IF1.
- READ_A: reg_sel=10, en_A=1. ALU -> READ_B; LDR/STR -> ADDR_CALC.
- READ_B: reg_sel=00, en_B=1 -> EXEC.
- EXEC: en_C=1; sel_A=1 for MOV reg; en_status=1 only for CMP (101/01). CMP -> IF1; all others -> WRITE.
- WRITE: reg_sel=01, wb_sel=00, w_en=1 -> IF1.
- ADDR_CALC: sel_B=1, en_C=1 -> LOAD_ADDR.
- LOAD_ADDR: load_addr=1. LDR -> MEM_RD; STR -> ST_RD.
- MEM_RD: addr_sel=0, mem_cmd=READ. Held 1+MEM_WAIT cycles -> LD_WB.
- LD_WB: addr_sel=0, mem_cmd=READ, reg_sel=01, wb_sel=11, w_en=1 -> IF1.
- ST_RD: reg_sel=01, en_B=1 -> ST_C.
- ST_C: sel_A=1, en_C=1 -> MEM_WR.
- MEM_WR: addr_sel=0, mem_cmd=WRITE for exactly 1 cycle -> IF1.
- HALT: halted=1, all else 0. Exited only by rst.
- rst mid-instruction: immediate return to RESET; the wait counter is cleared; no further w_en or WRITE is issued.
- Wait counter saturates at MEM_WAIT and is never compared while outside IF1/MEM_RD.

Decomposition:
- Package cpu_pkg holds:
  - state_t enum
  - opcode/op localparams (OP_MOV=110, OP_ALU=101, OP_LDR=011, OP_STR=100, OP_HALT=111)
  - REG_RN/REG_RM/REG_RD, WB_C/WB_IMM/WB_MDATA, MEM_NONE/MEM_READ/MEM_WRITE
- One sub-module, mem_wait_counter: clear, enable, done = (count == MEM_WAIT).

Test Plan:
- Reset, MEM_WAIT=1: hold rst 2 cycles -> reset_pc=1, load_pc=1; release -> IF1 mem_cmd=01 for 2 cycles, then IF2 load_ir=1, UPDATE_PC load_pc=1, DECODE all-zero.
- MOV imm (110/10): after DECODE -> one cycle reg_sel=10, wb_sel=10, w_en=1, then IF1 (mem_cmd=01, addr_sel=1).
- ADD (101/00) then CMP (101/01): READ_A (reg_sel=10, en_A), READ_B (reg_sel=00, en_B), EXEC (en_C=1, en_status=0 for ADD / 1 for CMP). ADD then WRITE (reg_sel=01, w_en); CMP goes straight to IF1 with no w_en.
- LDR with MEM_WAIT=3: ADDR_CALC sel_B=1, en_C=1; LOAD_ADDR load_addr=1; MEM_RD addr_sel=0, mem_cmd=01 for 4 cycles; LD_WB wb_sel=11, reg_sel=01, w_en=1.
- STR: ST_RD reg_sel=01, en_B; ST_C sel_A=1, en_C; exactly one cycle mem_cmd=10, addr_sel=0.
- HALT (111) and undefined 000: halted=1 held for 20 cycles with mem_cmd=00. With HALT_ON_UNDEF=0, 000 goes DECODE -> IF1. Pulsing rst during MEM_RD -> RESET with mem_cmd=00 and w_en never asserted.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types, encodings and instruction decode for the SRM control FSM
package cpu_pkg;

  typedef enum logic [4:0] {
    S_RESET, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WR_IMM,
    S_READ_A, S_READ_B, S_EXEC, S_WRITE, S_ADDR_CALC, S_LOAD_ADDR,
    S_MEM_RD, S_LD_WB, S_ST_RD, S_ST_C, S_MEM_WR, S_HALT
  } state_t;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] MEM_OP  = 2'b00;

  localparam logic [1:0] REG_RN = 2'b10;
  localparam logic [1:0] REG_RM = 2'b00;
  localparam logic [1:0] REG_RD = 2'b01;

  localparam logic [1:0] WB_C     = 2'b00;
  localparam logic [1:0] WB_IMM   = 2'b10;
  localparam logic [1:0] WB_MDATA = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // Successor of DECODE for a given {opcode, op}
  function automatic state_t decode_next(input logic [2:0] opc, input logic [1:0] o,
                                         input logic halt_on_undef);
    state_t undef_s;
    state_t nxt;
    undef_s = halt_on_undef ? S_HALT : S_IF1;
    nxt     = undef_s;
    case (opc)
      OP_MOV:  nxt = (o == MOV_IMM) ? S_WR_IMM : ((o == MOV_REG) ? S_READ_B : undef_s);
      OP_ALU:  nxt = S_READ_A;
      OP_LDR:  nxt = (o == MEM_OP) ? S_READ_A : undef_s;
      OP_STR:  nxt = (o == MEM_OP) ? S_READ_A : undef_s;
      OP_HALT: nxt = S_HALT;
      default: nxt = undef_s;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - saturating 4-bit memory-read wait counter
module mem_wait_counter #(
  parameter int MEM_WAIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic done_o
);

  localparam logic [3:0] LIMIT = MEM_WAIT[3:0];

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= 4'd0;
    else     count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (clear_i)                           count_d = 4'd0;
    else if (enable_i && count_q != LIMIT) count_d = count_q + 4'd1;
  end

  assign done_o = (count_q == LIMIT);

endmodule

// File: rtl/cpu_controller_fsm.sv
// rtl/cpu_controller_fsm.sv - Moore control FSM: fetch, PC update, decode, ALU/LDR/STR/HALT
module cpu_controller_fsm
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT      = 1,
  parameter int HALT_ON_UNDEF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  localparam logic HALT_UNDEF = (HALT_ON_UNDEF != 0);

  state_t state_q;
  state_t state_d;
  logic   wait_state;
  logic   wait_done;

  // Counter runs only in the two read-wait states, so it is zero on every entry to them
  assign wait_state = (state_q == S_IF1) || (state_q == S_MEM_RD);

  mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!wait_state),
    .enable_i (wait_state),
    .done_o   (wait_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    reg_sel   = REG_RM;
    wb_sel    = WB_C;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;

    case (state_q)
      S_RESET: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
        state_d  = S_IF1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        if (wait_done) state_d = S_IF2;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
        state_d  = S_UPDATE_PC;
      end
      S_UPDATE_PC: begin
        load_pc = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = decode_next(opcode, op, HALT_UNDEF);
      S_WR_IMM: begin
        reg_sel = REG_RN;
        wb_sel  = WB_IMM;
        w_en    = 1'b1;
        state_d = S_IF1;
      end
      S_READ_A: begin
        reg_sel = REG_RN;
        en_A    = 1'b1;
        state_d = (opcode == OP_ALU) ? S_READ_B : S_ADDR_CALC;
      end
      S_READ_B: begin
        reg_sel = REG_RM;
        en_B    = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        en_C      = 1'b1;
        sel_A     = (opcode == OP_MOV);
        en_status = (opcode == OP_ALU) && (op == ALU_CMP);
        state_d   = ((opcode == OP_ALU) && (op == ALU_CMP)) ? S_IF1 : S_WRITE;
      end
      S_WRITE: begin
        reg_sel = REG_RD;
        wb_sel  = WB_C;
        w_en    = 1'b1;
        state_d = S_IF1;
      end
      S_ADDR_CALC: begin
        sel_B   = 1'b1;
        en_C    = 1'b1;
        state_d = S_LOAD_ADDR;
      end
      S_LOAD_ADDR: begin
        load_addr = 1'b1;
        state_d   = (opcode == OP_LDR) ? S_MEM_RD : S_ST_RD;
      end
      S_MEM_RD: begin
        mem_cmd = MEM_READ;
        if (wait_done) state_d = S_LD_WB;
      end
      S_LD_WB: begin
        mem_cmd = MEM_READ;
        reg_sel = REG_RD;
        wb_sel  = WB_MDATA;
        w_en    = 1'b1;
        state_d = S_IF1;
      end
      S_ST_RD: begin
        reg_sel = REG_RD;
        en_B    = 1'b1;
        state_d = S_ST_C;
      end
      S_ST_C: begin
        sel_A   = 1'b1;
        en_C    = 1'b1;
        state_d = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_cmd = MEM_WRITE;
        state_d = S_IF1;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_RESET;
    endcase
  end

endmodule
